yp_fifo_rd_stream: RTL and testbench

Read-side adapter placed directly downstream of the team's synchronous FIFO. It drives the FIFO read enable, captures the one-cycle-late registered read data, and presents it on a valid/ready stream. A 2-entry output buffer sustains one word per cycle under continuous `i_ready` and absorbs back-pressure without losing in-flight words.

---
 rtl/yp_fifo_pkg.sv | 9 +
 rtl/yp_fifo_rd_buf.sv | 38 +++
 rtl/yp_fifo_rd_stream.sv | 60 ++++++
 tb/tb_yp_fifo_rd_stream.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/yp_fifo_pkg.sv
// yp_fifo_pkg: shared occupancy type and buffer depth for the FIFO read-side stream adapter.
package yp_fifo_pkg;
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } yp_rd_occ_e;
   localparam int YP_RD_BUF_DEPTH = 2;
endpackage

// File: rtl/yp_fifo_rd_buf.sv
// yp_fifo_rd_buf: 2-entry head/tail output buffer; captures FIFO read data and pops on handshake.
module yp_fifo_rd_buf
   import yp_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   input  logic                  i_cap,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output yp_rd_occ_e            o_occ,
   output logic [DATA_WIDTH-1:0] o_head
);
   logic [DATA_WIDTH-1:0] tail;
   logic                  cap_head;
   logic [1:0]            occ_nxt;

   // a capture lands in the head whenever the head is (or is about to become) free
   assign cap_head = i_cap & ((o_occ == OCC_EMPTY) | ((o_occ == OCC_ONE) & i_pop));
   assign occ_nxt  = 2'(o_occ) + {1'b0, i_cap} - {1'b0, i_pop};

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_occ  <= OCC_EMPTY;
         o_head <= '0;
         tail   <= '0;
      end else if (i_flush) begin
         o_occ <= OCC_EMPTY;
      end else begin
         o_occ <= yp_rd_occ_e'(occ_nxt);
         if (cap_head) o_head <= i_data;
         else if (i_pop && o_occ == OCC_TWO) o_head <= tail;
         if (i_cap && !cap_head) tail <= i_data;
      end
   end
endmodule

// File: rtl/yp_fifo_rd_stream.sv
// yp_fifo_rd_stream: FIFO read-side adapter presenting registered FIFO data on a valid/ready stream.
// Optional handshake counter port o_xfer_cnt is enabled by defining YP_FIFO_RD_CNT_EN.
module yp_fifo_rd_stream
   import yp_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   output logic                  o_fifo_rd_en,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data
`ifdef YP_FIFO_RD_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  o_xfer_cnt
`endif
);
   yp_rd_occ_e occ;
   logic       inflight;
   logic       pop;
   logic [1:0] credit;

   if (CNT_WIDTH < 1) begin : g_cnt_width_check
      $error("CNT_WIDTH must be at least 1");
   end

   assign o_valid = (occ != OCC_EMPTY) & ~i_flush;
   assign pop     = o_valid & i_ready;
   // words that will occupy the buffer after this edge; a new read must still fit
   assign credit       = 2'(occ) + {1'b0, inflight} - {1'b0, pop};
   assign o_fifo_rd_en = i_rstn & ~i_fifo_empty & ~i_flush & (credit < 2'(YP_RD_BUF_DEPTH));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) inflight <= 1'b0;
      else         inflight <= o_fifo_rd_en;
   end

   yp_fifo_rd_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_flush (i_flush),
      .i_cap   (inflight),
      .i_data  (i_fifo_data),
      .i_pop   (pop),
      .o_occ   (occ),
      .o_head  (o_data)
   );

`ifdef YP_FIFO_RD_CNT_EN
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)  o_xfer_cnt <= '0;
      else if (pop) o_xfer_cnt <= o_xfer_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_yp_fifo_rd_stream.sv
// tb_yp_fifo_rd_stream: directed bench with a FIFO model and an in-order scoreboard.
module tb_yp_fifo_rd_stream;
   localparam int DW = 8;
   localparam int CW = 4;

   logic i_clk = 0, i_rstn = 0, i_flush = 0, i_ready = 0;
   logic o_fifo_rd_en, i_fifo_empty, o_valid;
   logic [DW-1:0] i_fifo_data, o_data;
`ifdef YP_FIFO_RD_CNT_EN
   logic [CW-1:0] o_xfer_cnt;
`endif

   logic          wr_en = 0;
   logic [DW-1:0] wr_data = 0;
   logic [DW-1:0] mem [0:255];
   int            wp, rp;
   logic [DW-1:0] exp_q [$];
   int            n_asr = 0, n_fail = 0, rd_cnt = 0, rd_base = 0, pop_n = 0;
   logic          hold = 0;
   logic [DW-1:0] hold_d = 0;

   yp_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_flush      (i_flush),
      .o_fifo_rd_en (o_fifo_rd_en),
      .i_fifo_empty (i_fifo_empty),
      .i_fifo_data  (i_fifo_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data)
`ifdef YP_FIFO_RD_CNT_EN
      ,
      .o_xfer_cnt   (o_xfer_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   // synchronous FIFO with registered read data, reset by the same i_rstn
   assign i_fifo_empty = (wp == rp);
   always @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wp <= 0;
         rp <= 0;
         i_fifo_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wp[7:0]] <= wr_data;
            wp <= wp + 1;
         end
         if (o_fifo_rd_en) begin
            i_fifo_data <= mem[rp[7:0]];
            rp <= rp + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asr++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      wr_en = 1;
      wr_data = w;
      exp_q.push_back(w);
      step();
      wr_en = 0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      chk(tag, exp_q.size(), 0);
   endtask

   // handshake monitor: scoreboard pops and hold-stability checks
   always @(negedge i_clk) begin
      if (i_rstn) begin
         if (o_fifo_rd_en) rd_cnt++;
         if (hold && !i_flush) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_data", o_data, hold_d);
         end
         if (o_valid && i_ready) begin
            pop_n++;
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("sb_data", o_data, exp_q.pop_front());
         end
      end
      hold = i_rstn && o_valid && !i_ready;
      hold_d = o_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      step(2);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_rd_en", o_fifo_rd_en, 0);
`ifdef YP_FIFO_RD_CNT_EN
      chk("rst_xfer_cnt", o_xfer_cnt, 0);
`endif
      i_rstn = 1;
      i_ready = 1;
      step();
      // basic read and first-word latency
      fork
         begin
            push(8'h11);
            push(8'h22);
            push(8'h33);
         end
         begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge i_clk);
               seen = o_fifo_rd_en;
            end
            chk("first_rd_en", seen, 1);
            @(negedge i_clk); chk("lat_n1_valid", o_valid, 0);
            @(negedge i_clk); chk("lat_n2_valid", o_valid, 1); chk("lat_n2_data", o_data, 8'h11);
            @(negedge i_clk); chk("lat_n3_data", o_data, 8'h22);
            @(negedge i_clk); chk("lat_n4_data", o_data, 8'h33);
         end
      join
      drain("basic_drain");
      // back-pressure: only two reads may be issued
      i_ready = 0;
      rd_base = rd_cnt;
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      step(10);
      chk("bp_rd_pulses", rd_cnt - rd_base, 2);
      chk("bp_valid", o_valid, 1);
      chk("bp_data", o_data, 8'hA0);
      i_ready = 1;
      drain("bp_drain");
      // toggling ready
      for (int i = 0; i < 32; i++) begin
         i_ready = i[0];
         push(8'h40 + 8'(i));
      end
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         i_ready = ~i_ready;
         step();
      end
      chk("tog_drain", exp_q.size(), 0);
      // flush with a full buffer; the two buffered words are lost
      i_ready = 0;
      for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
      step(6);
      chk("pre_flush_valid", o_valid, 1);
      chk("pre_flush_data", o_data, 8'h60);
      i_flush = 1;
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      @(negedge i_clk);
      chk("flush_valid", o_valid, 0);
      chk("flush_rd_en", o_fifo_rd_en, 0);
      step();
      i_flush = 0;
      i_ready = 1;
      @(negedge i_clk);
      chk("post_flush_valid", o_valid, 0);
      step();
      drain("flush_drain");
`ifdef YP_FIFO_RD_CNT_EN
      chk("flush_xfer_cnt", o_xfer_cnt, pop_n % 16);
`endif
      // asynchronous reset in the middle of a burst
      i_ready = 0;
      for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
      step(4);
      i_ready = 1;
      step(2);
      chk("pre_arst_valid", o_valid, 1);
      #1 i_rstn = 0;
      exp_q.delete();
      pop_n = 0;
      #1;
      chk("arst_valid", o_valid, 0);
      chk("arst_data", o_data, 0);
      chk("arst_rd_en", o_fifo_rd_en, 0);
      step(2);
      i_rstn = 1;
      step();
`ifdef YP_FIFO_RD_CNT_EN
      chk("arst_xfer_cnt", o_xfer_cnt, 0);
`endif
      // 17 handshakes after reset; counter wraps at 16
      for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
      drain("wrap_drain");
`ifdef YP_FIFO_RD_CNT_EN
      chk("cnt_wrap", o_xfer_cnt, 1);
      i_flush = 1;
      step();
      i_flush = 0;
      step();
      chk("cnt_after_flush", o_xfer_cnt, 1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
      $finish;
   end
endmodule
